led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Sequencer feeding the board LED output multiplexer. Owns the LED timebase, the rotating-shift pattern, the flash pattern, the direction and the shift/flash mode. Provides `o_mux_sel`, `o_shift_leds` and `o_flash_leds` that drive the mux's select and two data inputs. Inputs come from the board switches (enable, speed) and the push buttons (mode, direction, restart).

Parameters:
- N_LEDS, 4, width of each pattern register.
- NB_COUNT, 32, timebase counter width.
- LIMIT0, (2**23)-1, timebase terminal count for speed 0.
- LIMIT1, (2**24)-1, terminal count for speed 1.
- LIMIT2, (2**25)-1, terminal count for speed 2.
- LIMIT3, (2**26)-1, terminal count for speed 3.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  switch; 1 = timebase runs, 0 = timebase and patterns freeze
- i_speed  in  2  switch; selects LIMIT0..LIMIT3
- i_btn  in  3  raw asynchronous buttons: [0] mode toggle, [1] direction toggle, [2] restart
- o_mux_sel  out  1  0 = SHIFT, 1 = FLASH; drives the mux select
- o_shift_leds  out  N_LEDS  rotating one-hot pattern
- o_flash_leds  out  N_LEDS  all-off / all-on pattern
- o_dir  out  1  0 = left (toward MSB), 1 = right
- o_tick  out  1  one-cycle pulse, registered, after each pattern step

Behaviour:
- Clock and reset: one clock, `i_clk`. Reset is synchronous and active-high on `i_reset`, and overrides every other event.
- Reset values:
  - count = 0, mode = SHIFT(0), dir = 0
  - shift = {0..01}, flash = all 0, `o_tick` = 0
  - synchronizer and edge flops = 0
- Button path: each `i_btn` bit passes through a 2-FF synchronizer, then a registered rising-edge detect. A level first sampled high at edge k produces a one-cycle event acted on at edge k+2. A held button yields exactly one event. No debounce in this block.
- Timebase, when `i_enable` = 1:
  - L = LIMIT[i_speed], compared at full NB_COUNT width.
  - If count >= L: count <- 0 and a step occurs. Otherwise count <- count+1.
  - The ">=" comparison makes a speed change to a smaller limit mid-count step on the next edge; no stall for a counter wrap.
  - Period is L+1 cycles.
- Timebase, when `i_enable` = 0: count, patterns and mode/dir updates from steps hold. Button events are still processed.
- Step in SHIFT mode: rotate shift by one position. Left when dir = 0 (MSB wraps to LSB); right when dir = 1 (LSB wraps to MSB). Flash holds.
- Step in FLASH mode: flash <- ~flash. Shift holds.
- `o_tick`: high for the single cycle following the edge at which a step occurred.
- Mode event: toggle mode, count <- 0, shift <- {0..01}, flash <- 0.
- Restart event: same as a mode event but mode is unchanged.
- Direction event: toggle dir only; count and patterns untouched.
- Simultaneous events in one cycle:
  - Mode or restart event with a step: the event wins, no step, `o_tick` stays 0.
  - Direction event with a step: the step uses the old dir; the new dir applies from the next step.
  - Mode and restart events together: treated as one mode event.
  - Mode and direction events together: both applied.
- Outputs are taken directly from registers; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - localparams SHIFT = 1'b0, FLASH = 1'b1
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
  - button index constants BTN_MODE = 0, BTN_DIR = 1, BTN_RESTART = 2
  - the default LIMIT values
- One natural sub-module: `btn_edge`, a 2-FF synchronizer plus rising-edge pulse with the same clock and reset. It is instantiated once per button (generate loop over 3).
- Timebase, pattern registers and mode/dir stay in the top-level module.

Test Plan:
1. Reset then run: set LIMIT0..3 = 3,5,7,9; `i_speed` = 0; `i_enable` = 1 -> `o_tick` every 4 cycles; `o_shift_leds` goes 0001,0010,0100,1000,0001; `o_flash_leds` stays 0000; `o_mux_sel` = 0.
2. Mode event: pulse `i_btn[0]` for 1 cycle -> `o_mux_sel` = 1 exactly 2 edges after first sampling; count cleared; next `o_tick` 4 cycles later; `o_flash_leds` alternates 1111/0000; shift frozen at 0001.
3. Direction in SHIFT: from 0100, press `i_btn[1]` -> `o_dir` = 1; next steps give 0010,0001,1000. Press in the same cycle as a step -> that step still goes left.
4. Speed change and enable: count at 6 with `i_speed` = 2, switch to `i_speed` = 0 -> step on the next edge, then period 4. With `i_enable` = 0 for 20 cycles -> no `o_tick`, outputs constant.
5. Collision and hold: assert the restart button in the same cycle a step is due -> patterns reset, `o_tick` = 0. Holding `i_btn[0]` for 50 cycles -> mode toggles exactly once.
6. Reset mid-operation: assert `i_reset` during FLASH with dir = 1 -> next edge all outputs return to their reset values.

Source files
------------

// File: rtl/led_seq_ctrl_pkg.sv
// Shared constants for the LED sequencer: mode and direction encodings,
// button bit positions and the default timebase terminal counts.
package led_seq_ctrl_pkg;

  // Mode encoding; also the value driven onto the mux select
  localparam logic SHIFT = 1'b0;
  localparam logic FLASH = 1'b1;

  // Rotation direction of the shift pattern
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Bit positions inside the raw button bus
  localparam int BTN_MODE    = 0;
  localparam int BTN_DIR     = 1;
  localparam int BTN_RESTART = 2;
  localparam int N_BTN       = 3;

  // Default terminal counts, (2**23)-1 .. (2**26)-1
  localparam logic [31:0] LIMIT0_DEF = 32'h007F_FFFF;
  localparam logic [31:0] LIMIT1_DEF = 32'h00FF_FFFF;
  localparam logic [31:0] LIMIT2_DEF = 32'h01FF_FFFF;
  localparam logic [31:0] LIMIT3_DEF = 32'h03FF_FFFF;

endpackage

// File: rtl/led_seq_ctrl_btn_edge.sv
// Two-flop synchronizer for one raw button followed by a registered
// rising-edge detector. A level first sampled high at edge k makes
// o_pulse high between edges k+1 and k+2, so the consumer acts at k+2.
// A held button produces a single pulse; there is no debounce here.
module btn_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign o_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: timebase counter, rotating one-hot shift pattern,
// all-off/all-on flash pattern, direction and shift/flash mode.
// Every output comes straight from a register.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int                N_LEDS   = 4,
  parameter int                NB_COUNT = 32,
  parameter logic [NB_COUNT-1:0] LIMIT0 = NB_COUNT'(LIMIT0_DEF),
  parameter logic [NB_COUNT-1:0] LIMIT1 = NB_COUNT'(LIMIT1_DEF),
  parameter logic [NB_COUNT-1:0] LIMIT2 = NB_COUNT'(LIMIT2_DEF),
  parameter logic [NB_COUNT-1:0] LIMIT3 = NB_COUNT'(LIMIT3_DEF)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_speed,
  input  logic [2:0]        i_btn,
  output logic              o_mux_sel,
  output logic [N_LEDS-1:0] o_shift_leds,
  output logic [N_LEDS-1:0] o_flash_leds,
  output logic              o_dir,
  output logic              o_tick
);

  localparam logic [N_LEDS-1:0] SHIFT_INIT = N_LEDS'(1);

  logic [N_BTN-1:0]    btn_ev;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic                mode_q, mode_d;
  logic                dir_q, dir_d;
  logic [N_LEDS-1:0]   shift_q, shift_d;
  logic [N_LEDS-1:0]   flash_q, flash_d;
  logic                tick_q, tick_d;
  logic [NB_COUNT-1:0] limit;
  logic                step;
  logic                mode_ev;
  logic                restart_ev;
  logic                dir_ev;

  // Terminal count for the selected speed
  function automatic logic [NB_COUNT-1:0] sel_limit(input logic [1:0] spd);
    case (spd)
      2'd0:    sel_limit = LIMIT0;
      2'd1:    sel_limit = LIMIT1;
      2'd2:    sel_limit = LIMIT2;
      default: sel_limit = LIMIT3;
    endcase
  endfunction

  // One-position rotation; left moves toward the MSB with wrap to LSB
  function automatic logic [N_LEDS-1:0] rotate(input logic [N_LEDS-1:0] v,
                                               input logic              d);
    if (d == DIR_LEFT) rotate = {v[N_LEDS-2:0], v[N_LEDS-1]};
    else               rotate = {v[0], v[N_LEDS-1:1]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_edge u_btn_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn[gi]),
        .o_pulse (btn_ev[gi])
      );
    end
  endgenerate

  assign mode_ev    = btn_ev[BTN_MODE];
  assign restart_ev = btn_ev[BTN_RESTART];
  assign dir_ev     = btn_ev[BTN_DIR];

  // ">=" lets a switch to a shorter period step immediately instead of
  // running the counter all the way around.
  assign limit = sel_limit(i_speed);
  assign step  = i_enable && (count_q >= limit);

  // Next-state: mode/restart events beat steps; a direction event only
  // affects later steps because the rotation below uses dir_q.
  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    shift_d = shift_q;
    flash_d = flash_q;
    tick_d  = 1'b0;

    if (dir_ev) dir_d = ~dir_q;

    if (mode_ev || restart_ev) begin
      if (mode_ev) mode_d = ~mode_q;
      count_d = '0;
      shift_d = SHIFT_INIT;
      flash_d = '0;
    end else if (i_enable) begin
      if (step) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (mode_q == SHIFT) shift_d = rotate(shift_q, dir_q);
        else                 flash_d = ~flash_q;
      end else begin
        count_d = count_q + NB_COUNT'(1);
      end
    end
  end

  // State registers; reset overrides every event
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      mode_q  <= SHIFT;
      dir_q   <= DIR_LEFT;
      shift_q <= SHIFT_INIT;
      flash_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      shift_q <= shift_d;
      flash_q <= flash_d;
      tick_q  <= tick_d;
    end
  end

  assign o_mux_sel    = mode_q;
  assign o_shift_leds = shift_q;
  assign o_flash_leds = flash_q;
  assign o_dir        = dir_q;
  assign o_tick       = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with short terminal counts 3,5,7,9.
module tb_led_seq_ctrl;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_speed;
  logic [2:0] i_btn;
  logic       o_mux_sel;
  logic [3:0] o_shift_leds;
  logic [3:0] o_flash_leds;
  logic       o_dir;
  logic       o_tick;

  int n_tests;
  int n_fail;

  led_seq_ctrl #(
    .N_LEDS   (4),
    .NB_COUNT (32),
    .LIMIT0   (32'd3),
    .LIMIT1   (32'd5),
    .LIMIT2   (32'd7),
    .LIMIT3   (32'd9)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_speed      (i_speed),
    .i_btn        (i_btn),
    .o_mux_sel    (o_mux_sel),
    .o_shift_leds (o_shift_leds),
    .o_flash_leds (o_flash_leds),
    .o_dir        (o_dir),
    .o_tick       (o_tick)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges; inputs are driven and outputs sampled 1ns after the edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Clock until o_tick is seen; returns edges taken, or -1 on timeout
  task automatic tick_wait(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      if (o_tick) begin
        n = i;
        break;
      end
    end
  endtask

  // One-cycle press; event is applied at the third edge
  task automatic press(input int idx);
    i_btn[idx] = 1'b1;
    cyc(1);
    i_btn[idx] = 1'b0;
    cyc(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_shift"}, 32'(o_shift_leds), 32'h1);
    chk({tag, "_flash"}, 32'(o_flash_leds), 32'h0);
    chk({tag, "_mux"},   32'(o_mux_sel),    32'h0);
    chk({tag, "_dir"},   32'(o_dir),        32'h0);
    chk({tag, "_tick"},  32'(o_tick),       32'h0);
  endtask

  int         n;
  int         toggles;
  logic       prev_mux;
  logic       seen_tick;
  logic [3:0] exp_shift [4];

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    i_reset  = 1'b1;
    i_enable = 1'b1;
    i_speed  = 2'd0;
    i_btn    = 3'b000;
    cyc(3);
    i_reset = 1'b0;

    // 1. Reset state, then period-4 left rotation
    chk_reset_vals("rst");
    exp_shift[0] = 4'b0010;
    exp_shift[1] = 4'b0100;
    exp_shift[2] = 4'b1000;
    exp_shift[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick_wait(n);
      chk("run_period", 32'(n), 32'd4);
      chk("run_shift", 32'(o_shift_leds), 32'(exp_shift[k]));
      chk("run_flash", 32'(o_flash_leds), 32'h0);
      chk("run_mux", 32'(o_mux_sel), 32'h0);
    end

    // 2. Mode event: two edges after first sampling, then flash toggles
    i_btn[0] = 1'b1;
    cyc(1);
    i_btn[0] = 1'b0;
    cyc(1);
    chk("mode_k1_mux", 32'(o_mux_sel), 32'h0);
    cyc(1);
    chk("mode_k2_mux", 32'(o_mux_sel), 32'h1);
    tick_wait(n);
    chk("flash_period", 32'(n), 32'd4);
    chk("flash_on", 32'(o_flash_leds), 32'hF);
    chk("flash_shift_hold", 32'(o_shift_leds), 32'h1);
    tick_wait(n);
    chk("flash_period2", 32'(n), 32'd4);
    chk("flash_off", 32'(o_flash_leds), 32'h0);

    // 3. Back to SHIFT, step to 0100, then reverse direction
    press(0);
    chk("mode_back", 32'(o_mux_sel), 32'h0);
    tick_wait(n);
    tick_wait(n);
    chk("dir_pre", 32'(o_shift_leds), 32'b0100);
    press(1);
    chk("dir_set", 32'(o_dir), 32'h1);
    tick_wait(n);
    chk("dir_r1_wait", 32'(n), 32'd1);
    chk("dir_r1", 32'(o_shift_leds), 32'b0010);
    tick_wait(n);
    chk("dir_r2", 32'(o_shift_leds), 32'b0001);
    tick_wait(n);
    chk("dir_r3", 32'(o_shift_leds), 32'b1000);
    press(1);
    tick_wait(n);
    chk("dir_left_again", 32'(o_shift_leds), 32'b0001);
    chk("dir_left_val", 32'(o_dir), 32'h0);
    // Direction event on the same edge as a step: step uses old (left) dir
    cyc(1);
    i_btn[1] = 1'b1;
    cyc(1);
    i_btn[1] = 1'b0;
    cyc(2);
    chk("dircol_tick", 32'(o_tick), 32'h1);
    chk("dircol_shift", 32'(o_shift_leds), 32'b0010);
    chk("dircol_dir", 32'(o_dir), 32'h1);
    tick_wait(n);
    chk("dircol_next", 32'(o_shift_leds), 32'b0001);

    // 4. Speed 2 counts to 6, drop to speed 0: step on the next edge
    i_speed = 2'd2;
    cyc(6);
    chk("spd_no_tick", 32'(o_tick), 32'h0);
    i_speed = 2'd0;
    cyc(1);
    chk("spd_step_now", 32'(o_tick), 32'h1);
    chk("spd_shift", 32'(o_shift_leds), 32'b1000);
    tick_wait(n);
    chk("spd_period", 32'(n), 32'd4);
    chk("spd_shift2", 32'(o_shift_leds), 32'b0100);
    // Enable low: everything freezes
    i_enable  = 1'b0;
    seen_tick = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (o_tick || o_shift_leds != 4'b0100) seen_tick = 1'b1;
    end
    chk("en_freeze", 32'(seen_tick), 32'h0);
    i_enable = 1'b1;
    tick_wait(n);
    chk("en_resume_period", 32'(n), 32'd4);
    chk("en_resume_shift", 32'(o_shift_leds), 32'b0010);

    // 5. Restart collides with a due step: restart wins, no tick
    cyc(1);
    i_btn[2] = 1'b1;
    cyc(1);
    i_btn[2] = 1'b0;
    cyc(2);
    chk("rstcol_tick", 32'(o_tick), 32'h0);
    chk("rstcol_shift", 32'(o_shift_leds), 32'h1);
    chk("rstcol_mux", 32'(o_mux_sel), 32'h0);
    tick_wait(n);
    chk("rstcol_period", 32'(n), 32'd4);
    chk("rstcol_next", 32'(o_shift_leds), 32'b1000);
    // Held mode button toggles exactly once
    toggles  = 0;
    prev_mux = o_mux_sel;
    i_btn[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      if (o_mux_sel != prev_mux) toggles++;
      prev_mux = o_mux_sel;
    end
    i_btn[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (o_mux_sel != prev_mux) toggles++;
      prev_mux = o_mux_sel;
    end
    chk("hold_toggles", 32'(toggles), 32'd1);
    chk("hold_mux", 32'(o_mux_sel), 32'h1);

    // 6. Reset while in FLASH with dir right and flash lit
    for (int k = 0; k < 2; k++) begin
      if (o_flash_leds != 4'hF) tick_wait(n);
    end
    chk("pre_rst_flash", 32'(o_flash_leds), 32'hF);
    chk("pre_rst_dir", 32'(o_dir), 32'h1);
    i_reset = 1'b1;
    cyc(1);
    chk_reset_vals("midrst");
    i_reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
